// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: size codes, requester IDs,
// the request bundle and the byte-enable / alignment helpers.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [6:0]  addr;
    logic [31:0] wdata;
  } dmem_req_t;

  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: return 4'b0001 << offset;
      SZ_HALF: return 4'b0011 << offset;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return offset[0];
      SZ_WORD: return offset != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for one access: store byte enables and data
// replication, misalignment detection, and load lane extraction with extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] ram_rdata,
  output logic [3:0]  byte_en,
  output logic [31:0] lane_wdata,
  output logic        misaligned,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    misaligned = is_misaligned(size, offset);
    byte_en    = (we && !misaligned) ? byte_mask(size, offset) : 4'b0000;

    // Replication puts the data on every lane, so whichever lanes are enabled carry it.
    case (size)
      SZ_BYTE: lane_wdata = {4{wdata[7:0]}};
      SZ_HALF: lane_wdata = {2{wdata[15:0]}};
      default: lane_wdata = wdata;
    endcase

    shifted = ram_rdata >> {offset, 3'b000};
    case (size)
      SZ_BYTE: load_data = {{24{sign & shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_data = {{16{sign & shifted[15]}}, shifted[15:0]};
      default: load_data = ram_rdata;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter: grants one access per cycle (round-robin or
// fixed priority), drives the RAM port and returns a one-cycle-latency response.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [1:0]  m0_size,
  input  logic        m0_sign,
  input  logic [6:0]  m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,

  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [1:0]  m1_size,
  input  logic        m1_sign,
  input  logic [6:0]  m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,

  output logic [3:0]  ram_wen,
  output logic [4:0]  ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  logic        ptr_reg;
  logic        ptr_next;
  logic [1:0]  gnt_vec;
  logic        any_gnt;
  dmem_req_t   sel_req;
  logic [3:0]  byte_en;
  logic [31:0] lane_wdata;
  logic        misaligned;
  logic [31:0] load_data;
  logic [31:0] resp_data;

  // Grants are gated by resetn so nothing is issued while reset is held.
  always_comb begin
    gnt_vec = 2'b00;
    if (resetn) begin
      if (m0_req && m1_req) begin
        if ((RR_EN != 0) && (ptr_reg == REQ_DBG)) gnt_vec[1] = 1'b1;
        else                                      gnt_vec[0] = 1'b1;
      end else begin
        gnt_vec = {m1_req, m0_req};
      end
    end

    ptr_next = ptr_reg;
    if (gnt_vec[0])      ptr_next = REQ_DBG;
    else if (gnt_vec[1]) ptr_next = REQ_CPU;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ptr_reg <= REQ_CPU;
    else         ptr_reg <= ptr_next;
  end

  assign any_gnt = |gnt_vec;
  assign sel_req = gnt_vec[1] ? dmem_req_t'{m1_we, m1_size, m1_sign, m1_addr, m1_wdata}
                              : dmem_req_t'{m0_we, m0_size, m0_sign, m0_addr, m0_wdata};

  dmem_lane_align u_lane_align (
    .we         (sel_req.we),
    .size       (sel_req.size),
    .sign       (sel_req.sign),
    .offset     (sel_req.addr[1:0]),
    .wdata      (sel_req.wdata),
    .ram_rdata  (ram_rdata),
    .byte_en    (byte_en),
    .lane_wdata (lane_wdata),
    .misaligned (misaligned),
    .load_data  (load_data)
  );

  assign ram_wen   = any_gnt ? byte_en            : 4'b0000;
  assign ram_addr  = any_gnt ? sel_req.addr[6:2]  : 5'd0;
  assign ram_wdata = any_gnt ? lane_wdata         : 32'd0;
  assign resp_data = (misaligned || sel_req.we) ? 32'd0 : load_data;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_resp
      logic        rvalid_reg;
      logic        err_reg;
      logic [31:0] rdata_reg;

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          rvalid_reg <= 1'b0;
          err_reg    <= 1'b0;
          rdata_reg  <= 32'd0;
        end else begin
          rvalid_reg <= gnt_vec[gi];
          if (gnt_vec[gi]) begin
            err_reg   <= misaligned;
            rdata_reg <= resp_data;
          end
        end
      end
    end
  endgenerate

  assign m0_gnt    = gnt_vec[0];
  assign m1_gnt    = gnt_vec[1];
  assign m0_rvalid = g_resp[0].rvalid_reg;
  assign m0_err    = g_resp[0].err_reg;
  assign m0_rdata  = g_resp[0].rdata_reg;
  assign m1_rvalid = g_resp[1].rvalid_reg;
  assign m1_err    = g_resp[1].err_reg;
  assign m1_rdata  = g_resp[1].rdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a round-robin instance with a RAM model and a
// fixed-priority instance sharing the same requester inputs.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        m0_req, m0_we, m0_sign, m1_req, m1_we, m1_sign;
  logic [1:0]  m0_size, m1_size;
  logic [6:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;

  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [3:0]  ram_wen;
  logic [4:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  logic        fp_m0_gnt, fp_m0_rvalid, fp_m0_err, fp_m1_gnt, fp_m1_rvalid, fp_m1_err;
  logic [31:0] fp_m0_rdata, fp_m1_rdata;
  logic [3:0]  fp_ram_wen;
  logic [4:0]  fp_ram_addr;
  logic [31:0] fp_ram_wdata;
  logic [31:0] fp_ram_rdata;
  assign fp_ram_rdata = 32'd0;

  logic [31:0] mem [32];
  logic        mem_clr;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (ram_wen[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end
  end
  assign ram_rdata = mem[ram_addr];

  dmem_arbiter #(.RR_EN(1)) dut (
    .clk(clk), .resetn(resetn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_sign(m0_sign),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_sign(m1_sign),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  dmem_arbiter #(.RR_EN(0)) dut_fp (
    .clk(clk), .resetn(resetn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_sign(m0_sign),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_gnt(fp_m0_gnt), .m0_rvalid(fp_m0_rvalid),
    .m0_rdata(fp_m0_rdata), .m0_err(fp_m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_sign(m1_sign),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_gnt(fp_m1_gnt), .m1_rvalid(fp_m1_rvalid),
    .m1_rdata(fp_m1_rdata), .m1_err(fp_m1_err),
    .ram_wen(fp_ram_wen), .ram_addr(fp_ram_addr), .ram_wdata(fp_ram_wdata),
    .ram_rdata(fp_ram_rdata)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic m0_set(input logic req, input logic we, input logic [1:0] size,
                        input logic sign, input logic [6:0] addr, input logic [31:0] wdata);
    m0_req = req; m0_we = we; m0_size = size; m0_sign = sign; m0_addr = addr; m0_wdata = wdata;
  endtask

  task automatic m1_set(input logic req, input logic we, input logic [1:0] size,
                        input logic sign, input logic [6:0] addr, input logic [31:0] wdata);
    m1_req = req; m1_we = we; m1_size = size; m1_sign = sign; m1_addr = addr; m1_wdata = wdata;
  endtask

  task automatic post_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn  = 1'b0;
    mem_clr = 1'b1;
    m0_set(1'b1, 1'b1, SZ_WORD, 1'b0, 7'h08, 32'h1111_1111);
    m1_set(1'b1, 1'b1, SZ_WORD, 1'b0, 7'h0C, 32'h2222_2222);
    post_edge();
    post_edge();
    chk("rst_m0_gnt",    {31'd0, m0_gnt},    32'd0);
    chk("rst_m1_gnt",    {31'd0, m1_gnt},    32'd0);
    chk("rst_ram_wen",   {28'd0, ram_wen},   32'd0);
    chk("rst_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
    chk("rst_m1_err",    {31'd0, m1_err},    32'd0);
    chk("rst_m0_rdata",  m0_rdata,           32'd0);

    @(negedge clk);
    mem_clr = 1'b0;
    resetn  = 1'b1;
    m0_set(1'b0, 1'b0, SZ_BYTE, 1'b0, 7'h00, 32'd0);
    m1_set(1'b0, 1'b0, SZ_BYTE, 1'b0, 7'h00, 32'd0);

    // Word store then load at 0x08
    @(negedge clk);
    m0_set(1'b1, 1'b1, SZ_WORD, 1'b0, 7'h08, 32'hDEAD_BEEF);
    #1;
    chk("st_w_gnt",   {31'd0, m0_gnt},  32'd1);
    chk("st_w_wen",   {28'd0, ram_wen}, 32'h0000_000F);
    chk("st_w_addr",  {27'd0, ram_addr}, 32'd2);
    chk("st_w_wdata", ram_wdata,        32'hDEAD_BEEF);
    post_edge();
    chk("st_w_rvalid", {31'd0, m0_rvalid}, 32'd1);
    chk("st_w_rdata",  m0_rdata,          32'd0);
    @(negedge clk);
    m0_set(1'b1, 1'b0, SZ_WORD, 1'b0, 7'h08, 32'd0);
    #1;
    chk("ld_w_wen",  {28'd0, ram_wen},  32'd0);
    chk("ld_w_addr", {27'd0, ram_addr}, 32'd2);
    post_edge();
    chk("ld_w_rvalid", {31'd0, m0_rvalid}, 32'd1);
    chk("ld_w_rdata",  m0_rdata,          32'hDEAD_BEEF);

    // Byte store 0x80 at 0x0B then signed / unsigned byte loads
    @(negedge clk);
    m0_set(1'b1, 1'b1, SZ_BYTE, 1'b0, 7'h0B, 32'h0000_0080);
    #1;
    chk("st_b_wen",   {28'd0, ram_wen}, 32'h0000_0008);
    chk("st_b_wdata", ram_wdata,        32'h8080_8080);
    @(negedge clk);
    m0_set(1'b1, 1'b0, SZ_BYTE, 1'b1, 7'h0B, 32'd0);
    post_edge();
    chk("ld_b_sext", m0_rdata, 32'hFFFF_FF80);
    @(negedge clk);
    m0_set(1'b1, 1'b0, SZ_BYTE, 1'b0, 7'h0B, 32'd0);
    post_edge();
    chk("ld_b_zext", m0_rdata, 32'h0000_0080);
    @(negedge clk);
    m0_set(1'b0, 1'b0, SZ_BYTE, 1'b0, 7'h00, 32'd0);
    #1;
    chk("idle_gnt",   {30'd0, m1_gnt, m0_gnt}, 32'd0);
    chk("idle_wen",   {28'd0, ram_wen},       32'd0);
    chk("idle_addr",  {27'd0, ram_addr},      32'd0);
    chk("idle_wdata", ram_wdata,              32'd0);
    post_edge();
    chk("idle_rvalid", {31'd0, m0_rvalid}, 32'd0);
    chk("hold_rdata",  m0_rdata,          32'h0000_0080);

    // Reset pulse, then both requesters held for four cycles
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin
        m0_set(1'b1, 1'b0, SZ_WORD, 1'b0, 7'h08, 32'd0);
        m1_set(1'b1, 1'b0, SZ_WORD, 1'b0, 7'h0C, 32'd0);
      end
      #1;
      chk($sformatf("rr_m0_gnt%0d", i), {31'd0, m0_gnt},    (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rr_m1_gnt%0d", i), {31'd0, m1_gnt},    (i % 2 == 1) ? 32'd1 : 32'd0);
      chk($sformatf("fp_m0_gnt%0d", i), {31'd0, fp_m0_gnt}, 32'd1);
      chk($sformatf("fp_m1_gnt%0d", i), {31'd0, fp_m1_gnt}, 32'd0);
    end
    post_edge();
    chk("rr_m1_rvalid", {31'd0, m1_rvalid}, 32'd1);
    chk("rr_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
    chk("rr_m0_rdata",  m0_rdata,          32'h80AD_BEEF);

    // Misaligned half load and word store
    @(negedge clk);
    m1_set(1'b0, 1'b0, SZ_BYTE, 1'b0, 7'h00, 32'd0);
    m0_set(1'b1, 1'b0, SZ_HALF, 1'b0, 7'h05, 32'd0);
    #1;
    chk("mis_h_gnt", {31'd0, m0_gnt},  32'd1);
    chk("mis_h_wen", {28'd0, ram_wen}, 32'd0);
    post_edge();
    chk("mis_h_err",   {31'd0, m0_err}, 32'd1);
    chk("mis_h_rdata", m0_rdata,        32'd0);
    @(negedge clk);
    m0_set(1'b1, 1'b1, SZ_WORD, 1'b0, 7'h06, 32'h1234_5678);
    #1;
    chk("mis_w_wen",  {28'd0, ram_wen},  32'd0);
    chk("mis_w_addr", {27'd0, ram_addr}, 32'd1);
    post_edge();
    chk("mis_w_err",   {31'd0, m0_err}, 32'd1);
    chk("mis_w_rdata", m0_rdata,        32'd0);
    chk("mis_word1",   mem[1],          32'd0);
    @(negedge clk);
    m0_set(1'b1, 1'b0, SZ_WORD, 1'b0, 7'h04, 32'd0);
    post_edge();
    chk("ld_word1_err",   {31'd0, m0_err}, 32'd0);
    chk("ld_word1_rdata", m0_rdata,        32'd0);

    // Reset asserted mid-cycle during an m1 store
    @(negedge clk);
    m0_set(1'b0, 1'b0, SZ_BYTE, 1'b0, 7'h00, 32'd0);
    m1_set(1'b1, 1'b1, SZ_WORD, 1'b0, 7'h10, 32'hCAFE_F00D);
    #1;
    chk("rst_st_gnt_pre", {31'd0, m1_gnt}, 32'd1);
    #1;
    resetn = 1'b0;
    #1;
    chk("rst_st_gnt",    {31'd0, m1_gnt},    32'd0);
    chk("rst_st_wen",    {28'd0, ram_wen},   32'd0);
    chk("rst_st_rvalid", {31'd0, m0_rvalid}, 32'd0);
    post_edge();
    chk("rst_st_m1rv",  {31'd0, m1_rvalid}, 32'd0);
    chk("rst_st_word4", mem[4],             32'd0);
    @(negedge clk);
    resetn = 1'b1;
    m1_set(1'b0, 1'b0, SZ_BYTE, 1'b0, 7'h00, 32'd0);
    post_edge();
    chk("rel_m1rv", {31'd0, m1_rvalid}, 32'd0);
    @(negedge clk);
    m0_set(1'b1, 1'b0, SZ_WORD, 1'b0, 7'h10, 32'd0);
    m1_set(1'b1, 1'b0, SZ_WORD, 1'b0, 7'h10, 32'd0);
    #1;
    chk("rel_ptr_m0", {31'd0, m0_gnt}, 32'd1);
    chk("rel_ptr_m1", {31'd0, m1_gnt}, 32'd0);
    post_edge();
    chk("rel_word4_rd", m0_rdata, 32'd0);
    @(negedge clk);
    m0_set(1'b0, 1'b0, SZ_BYTE, 1'b0, 7'h00, 32'd0);
    #1;
    chk("rel_m1_gnt", {31'd0, m1_gnt}, 32'd1);

    // m1 store to word 31 immediately followed by m0 load of the same word
    @(negedge clk);
    m1_set(1'b1, 1'b1, SZ_WORD, 1'b0, 7'h7C, 32'hA5A5_5A5A);
    #1;
    chk("top_st_addr", {27'd0, ram_addr}, 32'd31);
    chk("top_st_gnt",  {31'd0, m1_gnt},   32'd1);
    post_edge();
    chk("top_st_m1rv", {31'd0, m1_rvalid}, 32'd1);
    chk("top_st_m1rd", m1_rdata,           32'd0);
    @(negedge clk);
    m1_set(1'b0, 1'b0, SZ_BYTE, 1'b0, 7'h00, 32'd0);
    m0_set(1'b1, 1'b0, SZ_WORD, 1'b0, 7'h7C, 32'd0);
    #1;
    chk("top_ld_addr", {27'd0, ram_addr}, 32'd31);
    chk("top_ld_gnt",  {31'd0, m0_gnt},   32'd1);
    post_edge();
    chk("top_ld_rvalid", {31'd0, m0_rvalid}, 32'd1);
    chk("top_ld_rdata",  m0_rdata,           32'hA5A5_5A5A);

    // Half store into the upper lanes, then signed half load
    @(negedge clk);
    m0_set(1'b1, 1'b1, SZ_HALF, 1'b0, 7'h7E, 32'h0000_BEEF);
    #1;
    chk("st_h_wen",   {28'd0, ram_wen}, 32'h0000_000C);
    chk("st_h_wdata", ram_wdata,        32'hBEEF_BEEF);
    @(negedge clk);
    m0_set(1'b1, 1'b0, SZ_HALF, 1'b1, 7'h7E, 32'd0);
    post_edge();
    chk("ld_h_sext", m0_rdata, 32'hFFFF_BEEF);
    chk("word31",    mem[31],  32'hBEEF_5A5A);

    @(negedge clk);
    m0_set(1'b0, 1'b0, SZ_BYTE, 1'b0, 7'h00, 32'd0);
    post_edge();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
- REQ-001 The block SHALL have parameter RR_EN, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority to requester 0.
- REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-003 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
- REQ-004 The block SHALL have ports mN_req, input, 1 bit (N = 0 CPU, N = 1 debug/DMA): access request, held until granted.
- REQ-005 The block SHALL have ports mN_we, input, 1 bit: 1 = store, 0 = load.
- REQ-006 The block SHALL have ports mN_size, input, 2 bits: 00 = byte, 01 = half, 10 = word, 11 = reserved (treated as misaligned).
- REQ-007 The block SHALL have ports mN_sign, input, 1 bit: sign-extend load data.
- REQ-008 The block SHALL have ports mN_addr, input, 7 bits: byte address; bits [6:2] select the word, bits [1:0] the byte.
- REQ-009 The block SHALL have ports mN_wdata, input, 32 bits: store data, right-justified.
- REQ-010 The block SHALL have ports mN_gnt, output, 1 bit: combinational grant in the cycle the access is issued.
- REQ-011 The block SHALL have ports mN_rvalid, output, 1 bit: one-cycle response pulse.
- REQ-012 The block SHALL have ports mN_rdata, output, 32 bits: aligned and extended load data.
- REQ-013 The block SHALL have ports mN_err, output, 1 bit: misaligned or reserved-size flag, valid with mN_rvalid.
- REQ-014 The block SHALL have port ram_wen, output, 4 bits: byte write enables to the data RAM.
- REQ-015 The block SHALL have port ram_addr, output, 5 bits: word address to the data RAM.
- REQ-016 The block SHALL have port ram_wdata, output, 32 bits: lane-shifted store data to the data RAM.
- REQ-017 The block SHALL have port ram_rdata, input, 32 bits: asynchronous read data from the data RAM.

Function
- REQ-018 The block SHALL issue at most one access per cycle, so exactly one or zero of m0_gnt/m1_gnt is high.
- REQ-019 When only one requester has req high, that requester SHALL be granted in the same cycle.
- REQ-020 When both requesters have req high and RR_EN=1, the requester not granted last SHALL win, and the priority pointer SHALL update on each grant.
- REQ-021 When both requesters have req high and RR_EN=0, m0 SHALL always win.
- REQ-022 In the grant cycle, ram_addr SHALL equal addr[6:2] of the winning requester.
- REQ-023 ram_wen SHALL be 0001<<addr[1:0] for a byte store, 0011<<addr[1:0] for a half store, and 1111 for a word store.
- REQ-024 ram_wdata SHALL be the replicated or shifted wdata so that the enabled lanes carry the data.
- REQ-025 Misalignment SHALL be defined as half with addr[0]=1, word with addr[1:0]≠00, or size=11.
- REQ-026 A misaligned access SHALL still be granted, ram_wen SHALL be 0000, and the response SHALL have err=1 and rdata=0.
- REQ-027 For a load, lane data selected by addr[1:0] SHALL be extracted from ram_rdata and registered at the grant-cycle edge.
- REQ-028 Registered load data SHALL be zero-extended when sign=0 and sign-extended when sign=1.
- REQ-029 For a store, rdata SHALL be 0.
- REQ-030 mN_rvalid SHALL pulse exactly one cycle after mN_gnt, giving a fixed latency of 1.
- REQ-031 Back-to-back grants SHALL be allowed, giving full throughput of one access per cycle.
- REQ-032 rdata and err SHALL hold their last value while rvalid=0.
- REQ-033 When there is no grant, ram_wen SHALL be 0000, and ram_addr and ram_wdata SHALL be 0.
- REQ-034 A store followed by a load to the same word in the next cycle SHALL return the newly written data.

Reset
- REQ-035 While resetn=0, the block SHALL asynchronously clear mN_rvalid, mN_err and mN_rdata to 0.
- REQ-036 While resetn=0, the block SHALL force the priority pointer to m0 and hold all grants and ram_wen at 0.
- REQ-037 A reset asserted during a grant cycle SHALL suppress that write, leave no pending response and cause no rvalid after release.
- REQ-038 The first grant after reset release SHALL follow the REQ-019 to REQ-021 rules with m0 preferred.

Structure
- REQ-039 A shared package dmem_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the requester IDs (REQ_CPU = 0, REQ_DBG = 1) and a function computing the byte-enable mask.
- REQ-040 The block SHALL contain one sub-module, dmem_lane_align, instantiated once on the winning requester's signals.
- REQ-041 dmem_lane_align SHALL be purely combinational: store byte-enable and wdata shifting, misalignment detection, and load lane extraction with extension.
- REQ-042 The arbiter core SHALL hold the pointer, the response registers and the grant muxing.

Verification
- REQ-043 The bench SHALL drive m0 word store addr=0x08, data 0xDEADBEEF, then a load of 0x08 -> ram_wen=1111, ram_addr=2, and m0_rdata=0xDEADBEEF with rvalid one cycle after the load grant.
- REQ-044 The bench SHALL store byte 0x80 at 0x0B, then load byte sign=1 and sign=0 at 0x0B -> ram_wen=1000, rdata=0xFFFFFF80 then 0x00000080.
- REQ-045 The bench SHALL hold both req high for 4 cycles with RR_EN=1 -> grants m0, m1, m0, m1; with RR_EN=0 -> grants m0 four times.
- REQ-046 The bench SHALL issue a half load at 0x05 and a word store at 0x06 -> ram_wen=0000, err=1, rdata=0, RAM word 1 unchanged.
- REQ-047 The bench SHALL assert resetn=0 mid-cycle during an m1 word store to 0x10 -> RAM word 4 unchanged, no m1_rvalid, and the pointer back at m0.
- REQ-048 The bench SHALL issue an m1 store followed immediately by an m0 load of word 31 (addr 0x7C) -> m0 reads the m1 data, checking wrap to the top word and the REQ-034 ordering.
